// File: rtl/barcode_entry_controller.sv
// barcode_entry_controller: keypad-to-barcode-register sequencer.
// Optional inactivity auto-clear is built only when BARCODE_TIMEOUT_EN is defined.
//
// Purpose
//   Pushes keypad digits into the 4-digit barcode shift register and clears
//   it on CLEAR, on lookup completion or on inactivity. ENTER with enough
//   digits starts a request/acknowledge lookup to the product table.
//
// Ports
//   CLOCK, RESET_N       system clock, synchronous active-low reset
//   KEY_VALID, KEY_CODE  keypad strobe and code (0-9, A=ENTER, B=CLEAR)
//   SR_ENABLE, SR_DIGIT  shift strobe and digit to the barcode register
//   SR_CLEAR_N           active-low clear to the barcode register
//   LOOKUP_REQ           lookup request, held until LOOKUP_ACK
//   LOOKUP_ACK/FOUND     lookup completion strobe and result
//   BUSY                 lookup in progress, keys dropped
//   DIGIT_COUNT          digits entered, saturating at 4
//   ITEM_VALID           pulse: lookup hit
//   NOT_FOUND            pulse: lookup miss
//   SHORT_ENTRY          pulse: ENTER with too few digits
//   TIMEOUT              pulse: inactivity auto-clear (0 without the macro)

module barcode_entry_controller #(
   parameter int unsigned MIN_DIGITS     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 250000000,
   parameter int unsigned TMR_W          = 28
) (
   input  logic       CLOCK,
   input  logic       RESET_N,
   input  logic       KEY_VALID,
   input  logic [3:0] KEY_CODE,
   output logic       SR_ENABLE,
   output logic [3:0] SR_DIGIT,
   output logic       SR_CLEAR_N,
   output logic       LOOKUP_REQ,
   input  logic       LOOKUP_ACK,
   input  logic       LOOKUP_FOUND,
   output logic       BUSY,
   output logic [2:0] DIGIT_COUNT,
   output logic       ITEM_VALID,
   output logic       NOT_FOUND,
   output logic       SHORT_ENTRY,
   output logic       TIMEOUT
);

   if (MIN_DIGITS < 1 || MIN_DIGITS > 4) begin : g_bad_min_digits
      $error("MIN_DIGITS must be 1..4");
   end
   if (((TIMEOUT_CYCLES - 1) >> TMR_W) != 0) begin : g_bad_tmr_w
      $error("TMR_W too narrow for TIMEOUT_CYCLES");
   end

   localparam logic [2:0] MIN_CNT = 3'(MIN_DIGITS);
   localparam logic [2:0] MAX_CNT = 3'd4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      REQUEST = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] count_q, count_d;
   logic       sr_en_d;
   logic [3:0] sr_digit_d;
   logic       sr_clr_d;
   logic       item_d, nf_d, short_d;
   logic       lookup_d;

   logic key_digit, key_enter, key_clear;

   assign key_digit = KEY_VALID && (KEY_CODE <= 4'd9);
   assign key_enter = KEY_VALID && (KEY_CODE == 4'hA);
   assign key_clear = KEY_VALID && (KEY_CODE == 4'hB);

`ifdef BARCODE_TIMEOUT_EN
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             tmo_d, tmo_q;
`endif

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      sr_en_d    = 1'b0;
      sr_digit_d = 4'd0;
      sr_clr_d   = 1'b0;
      item_d     = 1'b0;
      nf_d       = 1'b0;
      short_d    = 1'b0;
`ifdef BARCODE_TIMEOUT_EN
      tmr_d      = '0;
      tmo_d      = 1'b0;
`endif
      unique case (state_q)
         IDLE, COLLECT: begin
            unique case (1'b1)
               key_digit: begin
                  sr_en_d    = 1'b1;
                  sr_digit_d = KEY_CODE;
                  state_d    = COLLECT;
                  if (count_q != MAX_CNT) count_d = count_q + 3'd1;
               end
               key_enter: begin
                  if (count_q >= MIN_CNT) state_d = REQUEST;
                  else short_d = 1'b1;
               end
               key_clear: begin
                  sr_clr_d = 1'b1;
                  count_d  = 3'd0;
                  state_d  = IDLE;
               end
               default: begin
`ifdef BARCODE_TIMEOUT_EN
                  // A key arriving on the expiry cycle takes the branches
                  // above, so it always beats the timeout.
                  if (state_q == COLLECT) begin
                     if (tmr_q == TMR_LAST) begin
                        tmo_d    = 1'b1;
                        sr_clr_d = 1'b1;
                        count_d  = 3'd0;
                        state_d  = IDLE;
                     end else begin
                        tmr_d = tmr_q + 1'b1;
                     end
                  end
`endif
               end
            endcase
         end
         REQUEST: begin
            if (LOOKUP_ACK) begin
               item_d   = LOOKUP_FOUND;
               nf_d     = !LOOKUP_FOUND;
               sr_clr_d = 1'b1;
               count_d  = 3'd0;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = 3'd0;
         end
      endcase
      lookup_d = (state_d == REQUEST);
   end

   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         state_q     <= IDLE;
         count_q     <= 3'd0;
         SR_ENABLE   <= 1'b0;
         SR_DIGIT    <= 4'd0;
         SR_CLEAR_N  <= 1'b0;
         LOOKUP_REQ  <= 1'b0;
         BUSY        <= 1'b0;
         ITEM_VALID  <= 1'b0;
         NOT_FOUND   <= 1'b0;
         SHORT_ENTRY <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         SR_ENABLE   <= sr_en_d;
         SR_DIGIT    <= sr_digit_d;
         SR_CLEAR_N  <= !sr_clr_d;
         LOOKUP_REQ  <= lookup_d;
         BUSY        <= lookup_d;
         ITEM_VALID  <= item_d;
         NOT_FOUND   <= nf_d;
         SHORT_ENTRY <= short_d;
      end
   end

   assign DIGIT_COUNT = count_q;

`ifdef BARCODE_TIMEOUT_EN
   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         tmr_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         tmr_q <= tmr_d;
         tmo_q <= tmo_d;
      end
   end

   assign TIMEOUT = tmo_q;
`else
   assign TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_barcode_entry_controller.sv
// tb_barcode_entry_controller: directed + random bench for the
// barcode entry controller, checked against a queue-based model.

module tb_barcode_entry_controller;

   localparam int MIN_D = 4;
   localparam int TMO   = 16;

   logic       CLOCK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       KEY_VALID = 1'b0;
   logic [3:0] KEY_CODE = 4'd0;
   logic       LOOKUP_ACK = 1'b0;
   logic       LOOKUP_FOUND = 1'b0;
   logic       SR_ENABLE, SR_CLEAR_N, LOOKUP_REQ, BUSY;
   logic [3:0] SR_DIGIT;
   logic [2:0] DIGIT_COUNT;
   logic       ITEM_VALID, NOT_FOUND, SHORT_ENTRY, TIMEOUT;

   barcode_entry_controller #(
      .MIN_DIGITS    (MIN_D),
      .TIMEOUT_CYCLES(TMO),
      .TMR_W         (5)
   ) dut (
      .CLOCK       (CLOCK),
      .RESET_N     (RESET_N),
      .KEY_VALID   (KEY_VALID),
      .KEY_CODE    (KEY_CODE),
      .SR_ENABLE   (SR_ENABLE),
      .SR_DIGIT    (SR_DIGIT),
      .SR_CLEAR_N  (SR_CLEAR_N),
      .LOOKUP_REQ  (LOOKUP_REQ),
      .LOOKUP_ACK  (LOOKUP_ACK),
      .LOOKUP_FOUND(LOOKUP_FOUND),
      .BUSY        (BUSY),
      .DIGIT_COUNT (DIGIT_COUNT),
      .ITEM_VALID  (ITEM_VALID),
      .NOT_FOUND   (NOT_FOUND),
      .SHORT_ENTRY (SHORT_ENTRY),
      .TIMEOUT     (TIMEOUT)
   );

   always #5 CLOCK = ~CLOCK;

   int errors = 0;
   int checks = 0;

   // reference model: digits since last clear, lookup pending flag, idle age
   int m_dig[$];
   int m_cnt;
   bit m_req;
   int m_idle;
   bit seen_tmo;

   // expected outputs for the current cycle
   bit       e_en, e_clrn, e_item, e_nf, e_short, e_tmo;
   logic [3:0] e_dig;

   // barcode register contents rebuilt from the DUT's strobes
   logic [15:0] mirror;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_cnt = 0;
      m_idle = 0;
      m_dig.delete();
      e_clrn = 1'b0;
   endtask

   task automatic model(input bit kv, input logic [3:0] code,
                        input bit ack, input bit fnd);
      e_en = 0; e_dig = 4'd0; e_clrn = 1; e_item = 0;
      e_nf = 0; e_short = 0; e_tmo = 0;
      if (m_req) begin
         if (ack) begin
            m_req = 0;
            if (fnd) e_item = 1;
            else e_nf = 1;
            model_clear();
         end
      end else if (kv && code <= 4'd9) begin
         e_en = 1;
         e_dig = code;
         if (m_cnt < 4) m_cnt++;
         m_dig.push_back(int'(code));
         if (m_dig.size() > 4) void'(m_dig.pop_front());
         m_idle = 0;
      end else if (kv && code == 4'hA) begin
         m_idle = 0;
         if (m_cnt >= MIN_D) m_req = 1;
         else e_short = 1;
      end else if (kv && code == 4'hB) begin
         model_clear();
      end
`ifdef BARCODE_TIMEOUT_EN
      else if (m_cnt > 0) begin
         if (m_idle == TMO - 1) begin
            e_tmo = 1;
            model_clear();
         end else begin
            m_idle++;
         end
      end
`endif
   endtask

   task automatic check_all(input string tag);
      logic [15:0] exp_reg;
      exp_reg = '0;
      foreach (m_dig[i]) exp_reg = {exp_reg[11:0], 4'(m_dig[i])};
      chk({tag, ".en"},    16'(SR_ENABLE),   16'(e_en));
      if (e_en) chk({tag, ".digit"}, 16'(SR_DIGIT), 16'(e_dig));
      chk({tag, ".clr_n"}, 16'(SR_CLEAR_N),  16'(e_clrn));
      chk({tag, ".req"},   16'(LOOKUP_REQ),  16'(m_req));
      chk({tag, ".busy"},  16'(BUSY),        16'(m_req));
      chk({tag, ".count"}, 16'(DIGIT_COUNT), 16'(m_cnt));
      chk({tag, ".item"},  16'(ITEM_VALID),  16'(e_item));
      chk({tag, ".nf"},    16'(NOT_FOUND),   16'(e_nf));
      chk({tag, ".short"}, 16'(SHORT_ENTRY), 16'(e_short));
      chk({tag, ".tmo"},   16'(TIMEOUT),     16'(e_tmo));
      chk({tag, ".reg"},   mirror,           exp_reg);
   endtask

   task automatic step(input string tag, input bit kv, input logic [3:0] code,
                       input bit ack, input bit fnd);
      KEY_VALID = kv;
      KEY_CODE = code;
      LOOKUP_ACK = ack;
      LOOKUP_FOUND = fnd;
      @(posedge CLOCK);
      #1;
      KEY_VALID = 1'b0;
      LOOKUP_ACK = 1'b0;
      model(kv, code, ack, fnd);
      if (SR_CLEAR_N !== 1'b1) mirror = '0;
      else if (SR_ENABLE === 1'b1) mirror = {mirror[11:0], SR_DIGIT};
      if (TIMEOUT === 1'b1) seen_tmo = 1'b1;
      check_all(tag);
   endtask

   task automatic key(input string tag, input logic [3:0] c);
      step(tag, 1'b1, c, 1'b0, 1'b0);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset(input int n);
      RESET_N = 1'b0;
      KEY_VALID = 1'b0;
      LOOKUP_ACK = 1'b0;
      repeat (n) @(posedge CLOCK);
      #1;
      m_req = 0;
      model_clear();
      e_en = 0; e_item = 0; e_nf = 0; e_short = 0; e_tmo = 0;
      mirror = '0;
      check_all("reset");
      chk("reset.digit", 16'(SR_DIGIT), 16'd0);
      RESET_N = 1'b1;
   endtask

   initial begin
      mirror = '0;
      seen_tmo = 1'b0;
      m_req = 0;
      m_cnt = 0;
      m_idle = 0;

      do_reset(2);
      idle("post_reset", 2);

      for (int d = 1; d <= 4; d++) key("dig1234", 4'(d));
      key("enter_hit", 4'hA);
      idle("wait_hit", 3);
      step("ack_found", 1'b0, 4'd0, 1'b1, 1'b1);
      idle("after_hit", 2);

      for (int d = 1; d <= 4; d++) key("dig1234b", 4'(d));
      key("enter_miss", 4'hA);
      step("ack_miss", 1'b0, 4'd0, 1'b1, 1'b0);
      idle("after_miss", 1);

      key("short7", 4'd7);
      key("short8", 4'd8);
      key("short_enter", 4'hA);
      idle("short_hold", 1);
      key("clear", 4'hB);
      idle("after_clear", 1);

      for (int d = 1; d <= 6; d++) key("dig1to6", 4'(d));
      key("enter6", 4'hA);
      key("busy_key9", 4'd9);
      key("busy_clear", 4'hB);
      step("busy_key_ack", 1'b1, 4'd9, 1'b1, 1'b1);
      idle("after_busy", 1);

      for (int d = 1; d <= 4; d++) key("dig_rst", 4'(d));
      key("enter_rst", 4'hA);
      idle("req_held", 1);
      do_reset(1);
      step("late_ack", 1'b0, 4'd0, 1'b1, 1'b1);
      idle("after_late", 1);

      key("ign_idle_c", 4'hC);
      key("ign_idle_f", 4'hF);
      key("dig3", 4'd3);
      key("ign_col_d", 4'hD);
      key("ign_col_e", 4'hE);
      step("stray_ack", 1'b0, 4'd0, 1'b1, 1'b0);
      key("clear2", 4'hB);

      seen_tmo = 1'b0;
      key("tmo_key5", 4'd5);
      idle("tmo_idle", TMO + 4);
`ifdef BARCODE_TIMEOUT_EN
      chk("timeout_seen", 16'(seen_tmo), 16'd1);
`else
      chk("no_timeout", 16'(seen_tmo), 16'd0);
`endif
      key("win_key5", 4'd5);
      idle("win_idle", TMO - 1);
      key("win_key6", 4'd6);
      idle("win_after", 3);
      key("clear3", 4'hB);

      for (int n = 0; n < 3000; n++) begin
         int r;
         bit kv, ack;
         logic [3:0] code;
         r = $urandom_range(0, 99);
         if (r < 3) begin
            idle("rnd_burst", TMO + 2);
         end else begin
            kv = ($urandom_range(0, 99) < 45);
            r = $urandom_range(0, 9);
            if (r < 6) code = 4'($urandom_range(0, 9));
            else if (r < 8) code = 4'hA;
            else if (r == 8) code = 4'hB;
            else code = 4'($urandom_range(0, 15));
            ack = ($urandom_range(0, 99) < 25);
            step("rnd", kv, code, ack, 1'($urandom_range(0, 1)));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
